pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction payload width.
REQ-002 SHALL have parameter PC_W, default 32: PC payload width.
REQ-003 SHALL have parameter NOP_INSTR, default all-zero (DATA_W bits): value loaded into the instruction on reset and flush.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port cpu_stall_i, input, 1 bit: cache-miss freeze of the whole stage.
REQ-007 SHALL have port flush_i, input, 1 bit: branch-taken flush; discards all held and incoming beats.
REQ-008 SHALL have port in_valid_i, input, 1 bit: upstream beat valid.
REQ-009 SHALL have port in_ready_o, output, 1 bit: stage accepts a beat.
REQ-010 SHALL have ports pc_i (input, PC_W) and instr_i (input, DATA_W): upstream payload.
REQ-011 SHALL have port out_valid_o, output, 1 bit: head beat valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: downstream accepts (deasserted on load-use hazard).
REQ-013 SHALL have ports pc_o (output, PC_W) and instr_o (output, DATA_W): head payload.
REQ-014 SHALL have port occupancy_o, output, 2 bits: held beats, 0..2.

Function
REQ-015 SHALL complete an input transfer when in_valid_i and in_ready_o are both 1 at a posedge, and an output transfer when out_valid_o and out_ready_i are both 1.
REQ-016 SHALL, with the skid feature, hold up to 2 beats in states EMPTY, ONE, FULL; in only: EMPTY->ONE, ONE->FULL; out only: FULL->ONE, ONE->EMPTY; in and out together: no state change, beats stay in FIFO order.
REQ-017 SHALL drive in_ready_o from a register: 1 unless state is FULL, with no combinational path from out_ready_i.
REQ-018 SHALL present the oldest beat on pc_o/instr_o with out_valid_o=1 whenever state is not EMPTY; latency in_valid_i to out_valid_o is 1 cycle from EMPTY.
REQ-019 SHALL keep pc_o/instr_o stable while out_valid_o=1 and out_ready_i=0.
REQ-020 SHALL, while cpu_stall_i=1, force in_ready_o=0 and out_valid_o=0 combinationally and freeze all registers, so no transfer completes.
REQ-021 SHALL, on flush_i=1 at a posedge, go to EMPTY, load pc registers with 0 and instruction registers with NOP_INSTR, and discard any beat offered that cycle.
REQ-022 SHALL give flush_i priority over cpu_stall_i, and rst_n_i priority over both.
REQ-023 SHALL drive occupancy_o = 0/1/2 for EMPTY/ONE/FULL, saturating with no wrap.
REQ-024 SHALL never accept a beat in FULL and never emit one in EMPTY; out_ready_i in EMPTY is ignored.

Reset
REQ-025 SHALL, when rst_n_i=0 at a posedge, enter EMPTY with pc registers 0, instruction registers NOP_INSTR and occupancy_o=0; outputs: out_valid_o=0, pc_o=0, instr_o=NOP_INSTR.
REQ-026 SHALL drive in_ready_o=0 for the reset cycle and 1 from the first cycle after rst_n_i returns to 1.
REQ-027 SHALL drop in-flight beats when reset is asserted mid-operation.

Configuration
REQ-028 SHALL compile the 2-entry skid buffer when PIPE_STAGE_REG_SKID_EN is defined.
REQ-029 SHALL, without PIPE_STAGE_REG_SKID_EN, hold one beat (EMPTY/ONE only) with in_ready_o = (!out_valid_o | out_ready_i) & !cpu_stall_i, combinational; occupancy_o never exceeds 1; all other requirements unchanged.

Structure
REQ-030 SHALL take the state enum (EMPTY, ONE, FULL) and the occupancy width constant from shared package pipe_pkg.
REQ-031 SHALL instantiate each payload slot as sub-module pipe_reg_entry (load enable, clear-to-NOP, PC+instr registers), twice with skid and once without.

Verification
REQ-032 SHALL check reset: rst_n_i=0 for 2 cycles then 1 -> out_valid_o=0, instr_o=NOP_INSTR, occupancy_o=0, in_ready_o=1 one cycle after release.
REQ-033 SHALL check streaming: in_valid_i=1 for 4 beats with pc 0x0,0x4,0x8,0xC and out_ready_i=1 -> same 4 beats in order, 1-cycle latency, occupancy_o stays 1.
REQ-034 SHALL check backpressure: out_ready_i=0 and 3 beats offered -> 2 accepted, in_ready_o=0 from the cycle after the second, occupancy_o=2; out_ready_i=1 then drains 0x0 before 0x4.
REQ-035 SHALL check flush: in FULL with flush_i=1 and a beat offered -> next cycle EMPTY, instr_o=NOP_INSTR, pc_o=0, offered beat never appears.
REQ-036 SHALL check stall: cpu_stall_i=1 for 5 cycles in ONE with in_valid_i=1 and out_ready_i=1 -> no transfers, payload unchanged, transfers resume the cycle after release.
REQ-037 SHALL check flush during stall: flush_i=1 and cpu_stall_i=1 together -> stage empties, and the stall freeze applies again from the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy width and
// the stage fill state, whose encoding doubles as the occupancy count.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_reg_entry.sv
// One payload slot of the pipeline stage: PC and instruction registers with
// load enable and a clear that restores PC=0 / instruction=NOP_INSTR.
module pipe_reg_entry #(
  parameter int                 DATA_W    = 32,
  parameter int                 PC_W      = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [PC_W-1:0]   pc_d,
  input  logic [DATA_W-1:0] instr_d,
  output logic [PC_W-1:0]   pc_q,
  output logic [DATA_W-1:0] instr_q
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (ld_i) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Fetch/decode pipeline stage register with stall freeze and branch flush.
// Define PIPE_STAGE_REG_SKID_EN for the 2-entry skid buffer; default holds one beat.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 PC_W      = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  pipe_state_e       state_q, state_d;
  logic              run_q;
  logic              in_fire, out_fire;
  logic              ld_head;
  logic [PC_W-1:0]   head_pc_d;
  logic [DATA_W-1:0] head_instr_d;

  // Stall gates both handshakes, so no fire (and no load) can happen while frozen.
  assign out_valid_o = (state_q != EMPTY) && !cpu_stall_i;
  assign out_fire    = out_valid_o && out_ready_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign occupancy_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              ld_skid, head_from_skid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_instr;

  // Ready depends only on registered state, breaking the out_ready_i path.
  assign in_ready_o = run_q && (state_q != FULL) && !cpu_stall_i;

  always_comb begin
    state_d        = state_q;
    ld_head        = 1'b0;
    ld_skid        = 1'b0;
    head_from_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            ld_head = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_head = 1'b1;
          end else if (in_fire) begin
            ld_skid = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            ld_head        = 1'b1;
            head_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign head_pc_d    = head_from_skid ? skid_pc    : pc_i;
  assign head_instr_d = head_from_skid ? skid_instr : instr_i;

  pipe_reg_entry #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .ld_i    (ld_skid),
    .pc_d    (pc_i),
    .instr_d (instr_i),
    .pc_q    (skid_pc),
    .instr_q (skid_instr)
  );
`else
  assign in_ready_o = run_q && !cpu_stall_i && (!out_valid_o || out_ready_i);

  always_comb begin
    state_d = state_q;
    ld_head = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (in_fire) begin
      ld_head = 1'b1;
      state_d = ONE;
    end else if (out_fire) begin
      state_d = EMPTY;
    end
  end

  assign head_pc_d    = pc_i;
  assign head_instr_d = instr_i;
`endif

  pipe_reg_entry #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_head (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .ld_i    (ld_head),
    .pc_d    (head_pc_d),
    .instr_d (head_instr_d),
    .pc_q    (pc_o),
    .instr_q (instr_o)
  );

endmodule
